// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
// Frame layout: start(0), 8 data bits LSB first, odd parity, stop(1).
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_state_e;

  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_REL = 8'hF0;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam int   DATA_BITS = 8;

endpackage

// File: rtl/ps2_if.sv
// Board-side pins and core-side key event outputs of the PS/2 receiver.
// The slave modport is the receiver; the master modport is the keyboard/core side.
interface ps2_if;
  logic       PS2_CLK;
  logic       PS2_DATA;
  logic [7:0] SCAN_CODE;
  logic       KEY_EXTENDED;
  logic       KEY_RELEASE;
  logic       SCAN_VALID;
  logic       FRAME_ERROR;

  modport slave (
    input  PS2_CLK, PS2_DATA,
    output SCAN_CODE, KEY_EXTENDED, KEY_RELEASE, SCAN_VALID, FRAME_ERROR
  );

  modport master (
    output PS2_CLK, PS2_DATA,
    input  SCAN_CODE, KEY_EXTENDED, KEY_RELEASE, SCAN_VALID, FRAME_ERROR
  );
endinterface

// File: rtl/ps2_line_filter.sv
// Two-flop synchronisers for both PS/2 pins plus a persistence filter on the clock line.
// Emits a registered one-cycle strobe when the filtered clock goes 1->0.
module ps2_line_filter #(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic data_sync,
  output logic fall
);

  localparam int CNT_W = $clog2(FILTER_LEN + 1);

  logic [1:0]       clk_sync_q, clk_sync_d;
  logic [1:0]       data_sync_q, data_sync_d;
  logic             filt_q, filt_d;
  logic             fall_q, fall_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The counter tracks how long the synchronised clock has disagreed with the
  // filtered value; any agreement restarts it, so short glitches never land.
  always_comb begin
    clk_sync_d  = {clk_sync_q[0], ps2_clk};
    data_sync_d = {data_sync_q[0], ps2_data};
    filt_d      = filt_q;
    fall_d      = 1'b0;
    cnt_d       = '0;
    if (clk_sync_q[1] != filt_q) begin
      if (cnt_q == CNT_W'(FILTER_LEN - 1)) begin
        filt_d = clk_sync_q[1];
        fall_d = ~clk_sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      filt_q      <= 1'b1;
      fall_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      clk_sync_q  <= clk_sync_d;
      data_sync_q <= data_sync_d;
      filt_q      <= filt_d;
      fall_q      <= fall_d;
      cnt_q       <= cnt_d;
    end
  end

  assign data_sync = data_sync_q[1];
  assign fall      = fall_q;

endmodule

// File: rtl/ps2_rx.sv
// PS/2 keyboard receiver: deserialises device-to-host frames, checks framing,
// folds E0/F0 prefixes into flags and pulses SCAN_VALID per key event.
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int FILTER_LEN     = 4
) (
  input  logic CLK_25MHZ,
  input  logic RESET,
  ps2_if.slave ps2
);

  localparam int TMR_W = $clog2(TIMEOUT_CYCLES);

  logic data_bit;
  logic fall;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
    .clk       (CLK_25MHZ),
    .rst       (RESET),
    .ps2_clk   (ps2.PS2_CLK),
    .ps2_data  (ps2.PS2_DATA),
    .data_sync (data_bit),
    .fall      (fall)
  );

  ps2_state_e       state_q, state_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             parity_q, parity_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             ext_q, ext_d;
  logic             rel_q, rel_d;
  logic [7:0]       scan_code_q, scan_code_d;
  logic             key_ext_q, key_ext_d;
  logic             key_rel_q, key_rel_d;
  logic             valid_q, valid_d;
  logic             error_q, error_d;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    parity_d    = parity_q;
    timer_d     = timer_q;
    ext_d       = ext_q;
    rel_d       = rel_q;
    scan_code_d = scan_code_q;
    key_ext_d   = key_ext_q;
    key_rel_d   = key_rel_q;
    valid_d     = 1'b0;
    error_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (fall) begin
          if (data_bit == START_BIT) begin
            state_d   = DATA;
            bit_cnt_d = '0;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      DATA: begin
        if (fall) begin
          shift_d   = {data_bit, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'(DATA_BITS - 1)) state_d = PARITY;
        end
      end
      PARITY: begin
        if (fall) begin
          parity_d = data_bit;
          state_d  = STOP;
        end
      end
      STOP: begin
        if (fall) begin
          state_d = IDLE;
          if (data_bit == STOP_BIT && (^{shift_q, parity_q})) begin
            if (shift_q == PS2_PREFIX_EXT) begin
              ext_d = 1'b1;
            end else if (shift_q == PS2_PREFIX_REL) begin
              rel_d = 1'b1;
            end else begin
              scan_code_d = shift_q;
              key_ext_d   = ext_q;
              key_rel_d   = rel_q;
              valid_d     = 1'b1;
              ext_d       = 1'b0;
              rel_d       = 1'b0;
            end
          end else begin
            error_d = 1'b1;
            ext_d   = 1'b0;
            rel_d   = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Inter-edge watchdog; a fall always wins, so timeout and a frame result never coincide.
    if (state_q != IDLE) begin
      if (fall) begin
        timer_d = '0;
      end else if (timer_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
        timer_d = '0;
        state_d = IDLE;
        error_d = 1'b1;
        ext_d   = 1'b0;
        rel_d   = 1'b0;
      end else begin
        timer_d = timer_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK_25MHZ or posedge RESET) begin
    if (RESET) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      parity_q    <= 1'b0;
      timer_q     <= '0;
      ext_q       <= 1'b0;
      rel_q       <= 1'b0;
      scan_code_q <= '0;
      key_ext_q   <= 1'b0;
      key_rel_q   <= 1'b0;
      valid_q     <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      parity_q    <= parity_d;
      timer_q     <= timer_d;
      ext_q       <= ext_d;
      rel_q       <= rel_d;
      scan_code_q <= scan_code_d;
      key_ext_q   <= key_ext_d;
      key_rel_q   <= key_rel_d;
      valid_q     <= valid_d;
      error_q     <= error_d;
    end
  end

  assign ps2.SCAN_CODE    = scan_code_q;
  assign ps2.KEY_EXTENDED = key_ext_q;
  assign ps2.KEY_RELEASE  = key_rel_q;
  assign ps2.SCAN_VALID   = valid_q;
  assign ps2.FRAME_ERROR  = error_q;

endmodule

// File: tb/tb_ps2_rx.sv
// Directed bench for ps2_rx: 40-cycle PS2_CLK half-period, TIMEOUT_CYCLES=1000.
`timescale 1ns/1ps
module tb_ps2_rx;
  import ps2_pkg::*;

  logic clk;
  logic rst;
  ps2_if bus ();

  ps2_rx #(.TIMEOUT_CYCLES(1000), .FILTER_LEN(4)) dut (
    .CLK_25MHZ (clk),
    .RESET     (rst),
    .ps2       (bus)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int valid_cnt = 0;
  int error_cnt = 0;
  int v_base;
  int e_base;
  logic lat_v [0:2];
  logic lat_e [0:2];
  logic early_err;
  logic to_e [0:1];

  always @(negedge clk) begin
    if (bus.SCAN_VALID)  valid_cnt++;
    if (bus.FRAME_ERROR) error_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Drives one bit; records outputs 6..8 cycles after the raw fall for latency checks.
  task automatic send_bit(input logic b);
    bus.PS2_DATA = b;
    repeat (20) @(negedge clk);
    bus.PS2_CLK = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i >= 6 && i <= 8) begin
        lat_v[i-6] = bus.SCAN_VALID;
        lat_e[i-6] = bus.FRAME_ERROR;
      end
    end
    bus.PS2_CLK = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic flip_parity);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit((~^d) ^ flip_parity);
    send_bit(1'b1);
  endtask

  initial begin
    rst = 1'b1;
    bus.PS2_CLK = 1'b1;
    bus.PS2_DATA = 1'b1;
    repeat (5) @(negedge clk);
    check("reset_code",  32'(bus.SCAN_CODE), 32'h00);
    check("reset_ext",   32'(bus.KEY_EXTENDED), 32'h0);
    check("reset_rel",   32'(bus.KEY_RELEASE), 32'h0);
    check("reset_valid", 32'(bus.SCAN_VALID), 32'h0);
    check("reset_err",   32'(bus.FRAME_ERROR), 32'h0);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // Plain make code with latency check
    send_frame(8'h1C, 1'b0);
    check("1c_lat6", 32'(lat_v[0]), 32'h0);
    check("1c_lat7", 32'(lat_v[1]), 32'h1);
    check("1c_lat8", 32'(lat_v[2]), 32'h0);
    check("1c_code", 32'(bus.SCAN_CODE), 32'h1C);
    check("1c_ext",  32'(bus.KEY_EXTENDED), 32'h0);
    check("1c_rel",  32'(bus.KEY_RELEASE), 32'h0);
    check("1c_vcnt", 32'(valid_cnt), 32'd1);
    check("1c_ecnt", 32'(error_cnt), 32'd0);

    // Extended break: E0 F0 75
    send_frame(8'hE0, 1'b0);
    send_frame(8'hF0, 1'b0);
    check("prefix_no_pulse", 32'(valid_cnt), 32'd1);
    send_frame(8'h75, 1'b0);
    check("75_vcnt", 32'(valid_cnt), 32'd2);
    check("75_code", 32'(bus.SCAN_CODE), 32'h75);
    check("75_ext",  32'(bus.KEY_EXTENDED), 32'h1);
    check("75_rel",  32'(bus.KEY_RELEASE), 32'h1);
    send_frame(8'h1C, 1'b0);
    check("1c2_code", 32'(bus.SCAN_CODE), 32'h1C);
    check("1c2_ext",  32'(bus.KEY_EXTENDED), 32'h0);
    check("1c2_rel",  32'(bus.KEY_RELEASE), 32'h0);

    // Parity error clears a pending F0
    send_frame(8'hF0, 1'b0);
    v_base = valid_cnt;
    e_base = error_cnt;
    send_frame(8'h1C, 1'b1);
    check("par_err_lat7", 32'(lat_e[1]), 32'h1);
    check("par_err_lat6", 32'(lat_e[0]), 32'h0);
    check("par_no_valid", 32'(lat_v[1]), 32'h0);
    check("par_ecnt", 32'(error_cnt - e_base), 32'd1);
    check("par_vcnt", 32'(valid_cnt - v_base), 32'd0);
    check("par_code_held", 32'(bus.SCAN_CODE), 32'h1C);
    send_frame(8'h75, 1'b0);
    check("after_par_code", 32'(bus.SCAN_CODE), 32'h75);
    check("after_par_rel",  32'(bus.KEY_RELEASE), 32'h0);
    check("after_par_ext",  32'(bus.KEY_EXTENDED), 32'h0);

    // Timeout after 5 data bits
    e_base = error_cnt;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    bus.PS2_DATA = 1'b1;
    repeat (20) @(negedge clk);
    bus.PS2_CLK = 1'b0;
    early_err = 1'b0;
    for (int i = 1; i <= 1010; i++) begin
      @(negedge clk);
      if (i == 40) bus.PS2_CLK = 1'b1;
      if (i < 1007 && bus.FRAME_ERROR) early_err = 1'b1;
      if (i == 1007) to_e[0] = bus.FRAME_ERROR;
      if (i == 1008) to_e[1] = bus.FRAME_ERROR;
    end
    check("to_not_early", 32'(early_err), 32'h0);
    check("to_fire",      32'(to_e[0]), 32'h1);
    check("to_one_cycle", 32'(to_e[1]), 32'h0);
    check("to_ecnt",      32'(error_cnt - e_base), 32'd1);
    check("to_idle",      32'(dut.state_q), 32'(IDLE));
    check("to_code_held", 32'(bus.SCAN_CODE), 32'h75);
    send_frame(8'h29, 1'b0);
    check("29_code", 32'(bus.SCAN_CODE), 32'h29);
    check("29_ext",  32'(bus.KEY_EXTENDED), 32'h0);
    check("29_rel",  32'(bus.KEY_RELEASE), 32'h0);

    // Glitch mid-frame, then asynchronous reset
    send_bit(1'b0);
    send_bit(1'b1);
    bus.PS2_CLK = 1'b0;
    repeat (2) @(negedge clk);
    bus.PS2_CLK = 1'b1;
    repeat (20) @(negedge clk);
    check("glitch_bitcnt", 32'(dut.bit_cnt_q), 32'd1);
    check("glitch_state",  32'(dut.state_q), 32'(DATA));
    #5;
    rst = 1'b1;
    #1;
    check("async_rst_code",  32'(bus.SCAN_CODE), 32'h00);
    check("async_rst_state", 32'(dut.state_q), 32'(IDLE));
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    send_frame(8'h5A, 1'b0);
    check("5a_code", 32'(bus.SCAN_CODE), 32'h5A);
    check("5a_ext",  32'(bus.KEY_EXTENDED), 32'h0);
    check("5a_rel",  32'(bus.KEY_RELEASE), 32'h0);
    check("5a_lat7", 32'(lat_v[1]), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_rx.md
# ps2_rx

PS/2 keyboard receiver sitting between the PS2_CLK/PS2_DATA board pins and the core's keyboard input. It synchronises and de-glitches both lines, deserialises 11-bit device-to-host frames, checks start/parity/stop and folds the E0/F0 prefixes into flags. Each completed key event is delivered as a one-cycle pulse carrying the scan code.

## Interface
- TIMEOUT_CYCLES, 50000: max CLK_25MHZ cycles between falling edges inside a frame (2 ms at 25 MHz).
- FILTER_LEN, 4: consecutive identical synchronised samples required before the filtered PS2_CLK changes.

Ports:
- CLK_25MHZ  in  1  sole clock; all state on rising edge.
- RESET  in  1  asynchronous, active-high reset.
- PS2_CLK  in  1  raw keyboard clock pin, asynchronous.
- PS2_DATA  in  1  raw keyboard data pin, asynchronous.
- SCAN_CODE  out  8  scan code of the last event; held until the next event.
- KEY_EXTENDED  out  1  the event was preceded by E0; valid with SCAN_VALID, held with SCAN_CODE.
- KEY_RELEASE  out  1  the event was preceded by F0; valid with SCAN_VALID, held with SCAN_CODE.
- SCAN_VALID  out  1  one-cycle pulse when a key event is delivered.
- FRAME_ERROR  out  1  one-cycle pulse on a bad start, parity or stop bit, or on a timeout.

## Operation
- Both pins pass through a 2-flop synchroniser.
- Clock filter: the filtered clock takes the synchronised value after FILTER_LEN consecutive equal samples. A 1→0 transition of the filtered clock is a "fall".
- Data is sampled from the synchronised PS2_DATA in the cycle the fall is detected.
- FSM states and transitions:
  - IDLE: on a fall with data=0 → DATA, bit counter 0. On a fall with data=1, stay in IDLE and pulse FRAME_ERROR.
  - DATA: on each fall, shift the bit in LSB-first (shift right, new bit at bit 7). After the 8th bit → PARITY.
  - PARITY: on a fall, store the parity bit → STOP.
  - STOP: on a fall, the frame is good iff stop=1 and XOR(data[7:0], parity)=1 (odd parity). Go to IDLE either way.
- Good frame handling:
  - 8'hE0: set the ext flag, no pulse.
  - 8'hF0: set the rel flag, no pulse.
  - Any other value: SCAN_CODE←byte, KEY_EXTENDED←ext, KEY_RELEASE←rel, pulse SCAN_VALID, then clear both flags.
- Bad frame: pulse FRAME_ERROR, clear both flags, leave SCAN_CODE and the KEY_* outputs unchanged.
- Timeout: a counter runs in any state other than IDLE and restarts on every fall. When it reaches TIMEOUT_CYCLES-1, pulse FRAME_ERROR, clear both flags and go to IDLE. The partial byte is discarded.
- The counter and the flags are idle and hold while in IDLE; prefix flags persist across idle gaps of any length.
- E1 (Pause) is not special and passes through as an ordinary code.
- Host-to-device transmission is not supported; the pins are input only.

## Timing
- Reset values:
  - Outputs: SCAN_CODE=0, KEY_EXTENDED=0, KEY_RELEASE=0, SCAN_VALID=0, FRAME_ERROR=0.
  - Internal: FSM=IDLE, synchroniser and filtered clock at 1, flags at 0, counters at 0.
- Latency from the raw PS2_CLK fall of the stop bit to SCAN_VALID high is exactly 2+FILTER_LEN+1 CLK_25MHZ edges (7 at the default). The same latency applies to FRAME_ERROR for a frame error.
- Timeout FRAME_ERROR fires TIMEOUT_CYCLES cycles after the last detected fall.
- SCAN_VALID and FRAME_ERROR are never high in the same cycle.
- Glitches on PS2_CLK shorter than FILTER_LEN cycles produce no fall.
- RESET mid-frame aborts immediately. The first fall after release with data=0 starts a new frame.
- Minimum supported PS2_CLK half-period is FILTER_LEN+3 cycles.

## Structure
- Package ps2_pkg holds:
  - the state enum (IDLE, DATA, PARITY, STOP);
  - PS2_PREFIX_EXT=8'hE0 and PS2_PREFIX_REL=8'hF0;
  - frame-bit constants.
- Sub-module ps2_line_filter contains the synchroniser and clock filter. It outputs the synchronised data and a one-cycle fall strobe, and is instantiated once.
- Top level ps2_rx holds the FSM, shift register, parity, timeout counter and prefix logic.

## Test plan
- Bench stimulus uses a PS2_CLK half-period of 40 cycles and TIMEOUT_CYCLES=1000.
- Frame 8'h1C with correct odd parity → one SCAN_VALID pulse 7 cycles after the stop fall; SCAN_CODE=8'h1C, KEY_EXTENDED=0, KEY_RELEASE=0.
- Frames E0, F0, 75 → a single SCAN_VALID with SCAN_CODE=8'h75, KEY_EXTENDED=1, KEY_RELEASE=1. No pulse for the prefixes. A following frame 1C gives both flags 0.
- Frame 8'h1C with the parity bit inverted → a FRAME_ERROR pulse, no SCAN_VALID, SCAN_CODE keeps its previous value. A prior F0 flag is cleared.
- Stop after 5 data bits → FRAME_ERROR exactly 1000 cycles after the last fall, FSM back in IDLE. The next full frame 8'h29 is received correctly.
- A 2-cycle low glitch on PS2_CLK in mid-frame plus RESET asserted mid-frame → the glitch shifts no bit, and the reset returns all outputs to 0 asynchronously. A clean frame 8'h5A after release decodes to 8'h5A.
